code_entry_controller: RTL

- Sequencing controller for the backdoor lock: collects multi-byte codes from the 8 switches on debounced enter pulses, checks them against a stored code, and drives unlock/fail/lockout status.
- Runs the change-code flow: new entry, confirm, commit.
- Sits between the debouncers and the LED / seven-segment scanner.
- Owns attempt counting and lockout timing. The slow divider supplies the timing strobe.

---
 rtl/backdoor_pkg.sv | 36 +++
 rtl/lockout_timer.sv | 36 +++
 rtl/code_entry_controller.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/backdoor_pkg.sv
// Shared types and constants for the backdoor lock code-entry controller.
package backdoor_pkg;

    typedef enum logic [2:0] {
        ENTRY,
        CHECK,
        FAIL,
        OPEN,
        NEW,
        CONFIRM,
        LOCKOUT
    } state_e;

    localparam int unsigned LED_W        = 6;
    localparam int unsigned LED_UNLOCK   = 0;
    localparam int unsigned LED_FAIL     = 1;
    localparam int unsigned LED_LOCKOUT  = 2;
    localparam int unsigned LED_CHANGE   = 3;
    localparam int unsigned LED_TRIES_LO = 4;
    localparam int unsigned LED_TRIES_HI = 5;

    localparam int unsigned SSD_W        = 16;
    localparam int unsigned SSD_DIGITS   = 4;
    localparam logic [15:0] SSD_OPEN     = 16'h0E0E;
    localparam logic [15:0] SSD_FAIL     = 16'hFFFF;

    // Each entered byte reveals two hex digits, filled from digit 0 upward.
    function automatic logic [3:0] blank_mask(input int unsigned n_bytes);
        logic [3:0] m;
        for (int unsigned i = 0; i < SSD_DIGITS; i++) begin
            m[i] = (i >= 2 * n_bytes);
        end
        return m;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable 16-bit down-counter advanced by the slow tick; holds at zero.
module lockout_timer (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] count_nxt_c,
    output logic        done_c
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        done_c  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != 16'd0)) begin
            count_d = count_q - 16'd1;
            done_c  = (count_q == 16'd1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_nxt_c = count_d;

endmodule

// File: rtl/code_entry_controller.sv
// Backdoor lock sequencer: code entry, check, change-code flow, lockout.
// Optional master code path enabled by defining BACKDOOR_MASTER_EN.
module code_entry_controller
    import backdoor_pkg::*;
#(
    parameter int unsigned            CODE_LEN   = 2,
    parameter int unsigned            MAX_TRIES  = 3,
    parameter int unsigned            LOCK_TICKS = 30,
    parameter logic [8*CODE_LEN-1:0]  RESET_CODE = (8*CODE_LEN)'(16'hBEEF)
`ifdef BACKDOOR_MASTER_EN
    ,
    parameter logic [8*CODE_LEN-1:0]  MASTER_CODE = (8*CODE_LEN)'(16'hC0DE)
`endif
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              tick,
    input  logic              clear,
    input  logic              enter,
    input  logic              change,
    input  logic [7:0]        sw,
    output logic [LED_W-1:0]  led,
    output logic [SSD_W-1:0]  ssd_val,
    output logic [3:0]        ssd_blank
);

    localparam int unsigned CW = 8 * CODE_LEN;
    localparam int unsigned IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   buf_q, buf_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      tries_q, tries_d;
    logic [CW-1:0]   code_q, code_d;
    logic [CW-1:0]   newcode_q, newcode_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [SSD_W-1:0] ssd_val_q, ssd_val_d;
    logic [3:0]      ssd_blank_q, ssd_blank_d;

    logic [CW-1:0]   shifted;
    logic            last_byte;
    logic            match;
    logic            tmr_load;
    logic [15:0]     tmr_load_val;
    logic [15:0]     tmr_count_nxt;
    logic            tmr_done;

    lockout_timer u_timer (
        .clk_in      (clk_in),
        .rst         (rst),
        .tick        (tick),
        .load        (tmr_load),
        .load_val    (tmr_load_val),
        .count_nxt_c (tmr_count_nxt),
        .done_c      (tmr_done)
    );

    // Next-state, datapath and registered-output decode from next state.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        idx_d        = idx_q;
        tries_d      = tries_q;
        code_d       = code_q;
        newcode_d    = newcode_q;
        tmr_load     = 1'b0;
        tmr_load_val = 16'd0;
        shifted      = CW'({buf_q, sw});
        last_byte    = (idx_q == IW'(CODE_LEN - 1));
`ifdef BACKDOOR_MASTER_EN
        match        = (buf_q == code_q) || (buf_q == MASTER_CODE);
`else
        match        = (buf_q == code_q);
`endif

        case (state_q)
            ENTRY, NEW, CONFIRM: begin
                if (clear) begin
                    buf_d = '0;
                    idx_d = '0;
                    if (state_q != ENTRY) state_d = OPEN;
                end else if (enter) begin
                    buf_d = shifted;
                    idx_d = idx_q + IW'(1);
                    if (last_byte) begin
                        idx_d = '0;
                        if (state_q == ENTRY) begin
                            state_d = CHECK;
                        end else if (state_q == NEW) begin
                            newcode_d = shifted;
                            buf_d     = '0;
                            state_d   = CONFIRM;
                        end else begin
                            if (shifted == newcode_q) code_d = newcode_q;
                            buf_d   = '0;
                            state_d = OPEN;
                        end
                    end
                end
            end
            CHECK: begin
                buf_d = '0;
                idx_d = '0;
                if (match) begin
                    state_d = OPEN;
                    tries_d = 2'd0;
                end else if (32'(tries_q) + 32'd1 >= 32'(MAX_TRIES)) begin
                    state_d      = LOCKOUT;
                    tries_d      = 2'(MAX_TRIES);
                    tmr_load     = 1'b1;
                    tmr_load_val = 16'(LOCK_TICKS);
                end else begin
                    state_d = FAIL;
                    tries_d = tries_q + 2'd1;
                end
            end
            FAIL: begin
                if (clear || enter) state_d = ENTRY;
            end
            OPEN: begin
                if (clear) begin
                    state_d = ENTRY;
                end else if (!enter && change) begin
                    state_d = NEW;
                end
            end
            LOCKOUT: begin
                if (tmr_done) begin
                    state_d = ENTRY;
                    tries_d = 2'd0;
                    buf_d   = '0;
                    idx_d   = '0;
                end
`ifdef BACKDOOR_MASTER_EN
                else if (enter) begin
                    buf_d = shifted;
                    idx_d = idx_q + IW'(1);
                    if (last_byte) begin
                        buf_d = '0;
                        idx_d = '0;
                        if (shifted == MASTER_CODE) begin
                            state_d  = OPEN;
                            tries_d  = 2'd0;
                            tmr_load = 1'b1;
                        end
                    end
                end
`endif
            end
            default: begin
                state_d = ENTRY;
            end
        endcase

        led_d = '0;
        led_d[LED_TRIES_HI:LED_TRIES_LO] = tries_d;
        ssd_val_d   = '0;
        ssd_blank_d = 4'hF;
        case (state_d)
            ENTRY, NEW, CONFIRM: begin
                ssd_val_d   = 16'(buf_d);
                ssd_blank_d = blank_mask(32'(idx_d));
                if (state_d != ENTRY) led_d[LED_CHANGE] = 1'b1;
            end
            FAIL: begin
                led_d[LED_FAIL] = 1'b1;
                ssd_val_d       = SSD_FAIL;
                ssd_blank_d     = 4'h0;
            end
            OPEN: begin
                led_d[LED_UNLOCK] = 1'b1;
                ssd_val_d         = SSD_OPEN;
                ssd_blank_d       = 4'h0;
            end
            LOCKOUT: begin
                led_d[LED_LOCKOUT] = 1'b1;
                ssd_val_d          = tmr_count_nxt;
                ssd_blank_d        = 4'h0;
            end
            default: begin
                ssd_blank_d = 4'hF;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= ENTRY;
            buf_q       <= '0;
            idx_q       <= '0;
            tries_q     <= 2'd0;
            code_q      <= RESET_CODE;
            newcode_q   <= '0;
            led_q       <= '0;
            ssd_val_q   <= '0;
            ssd_blank_q <= 4'hF;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            tries_q     <= tries_d;
            code_q      <= code_d;
            newcode_q   <= newcode_d;
            led_q       <= led_d;
            ssd_val_q   <= ssd_val_d;
            ssd_blank_q <= ssd_blank_d;
        end
    end

    assign led       = led_q;
    assign ssd_val   = ssd_val_q;
    assign ssd_blank = ssd_blank_q;

endmodule
